bp_sacc_dma_fill: RTL and testbench

BP_SACC_DMA_FILL -- requirements
Module: bp_sacc_dma_fill

---
 rtl/bp_sacc_dma_fill_if.sv | 33 +++
 rtl/bp_sacc_dma_fill.sv | 138 +++++++++++++
 tb/tb_bp_sacc_dma_fill.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bp_sacc_dma_fill_if.sv
// Memory read channel and scratchpad write port of the scratchpad fill DMA.
interface bp_sacc_dma_fill_if #(
  parameter int word_width_p  = 32,
  parameter int paddr_width_p = 40,
  parameter int num_spm_p     = 3,
  parameter int spm_els_p     = 4096
);
  localparam int sel_w_lp = (num_spm_p > 1) ? $clog2(num_spm_p) : 1;
  localparam int idx_w_lp = $clog2(spm_els_p);

  logic                     mem_cmd_v_o;
  logic [paddr_width_p-1:0] mem_cmd_addr_o;
  logic                     mem_cmd_yumi_i;
  logic                     mem_resp_v_i;
  logic [word_width_p-1:0]  mem_resp_data_i;
  logic                     mem_resp_ready_o;
  logic                     spm_w_v_o;
  logic [sel_w_lp-1:0]      spm_sel_o;
  logic [idx_w_lp-1:0]      spm_addr_o;
  logic [word_width_p-1:0]  spm_data_o;

  modport master (
    output mem_cmd_v_o, mem_cmd_addr_o, mem_resp_ready_o,
           spm_w_v_o, spm_sel_o, spm_addr_o, spm_data_o,
    input  mem_cmd_yumi_i, mem_resp_v_i, mem_resp_data_i
  );

  modport slave (
    input  mem_cmd_v_o, mem_cmd_addr_o, mem_resp_ready_o,
           spm_w_v_o, spm_sel_o, spm_addr_o, spm_data_o,
    output mem_cmd_yumi_i, mem_resp_v_i, mem_resp_data_i
  );
endinterface

// File: rtl/bp_sacc_dma_fill.sv
// Scratchpad fill DMA: reads len words from memory starting at a base address
// and writes them, in order, into the selected scratchpad.
module bp_sacc_dma_fill #(
  parameter int word_width_p      = 32,
  parameter int paddr_width_p     = 40,
  parameter int num_spm_p         = 3,
  parameter int spm_els_p         = 4096,
  parameter int max_outstanding_p = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     start_v_i,
  input  logic [paddr_width_p-1:0] start_addr_i,
  input  logic [$clog2(spm_els_p):0] start_len_i,
  input  logic [((num_spm_p > 1) ? $clog2(num_spm_p) : 1)-1:0] start_sel_i,
  input  logic                     abort_i,
  input  logic                     clear_i,
  bp_sacc_dma_fill_if.master       bus,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic                     aborted_o
);

  localparam int cnt_w_lp = $clog2(spm_els_p) + 1;
  localparam int idx_w_lp = $clog2(spm_els_p);
  localparam int sel_w_lp = (num_spm_p > 1) ? $clog2(num_spm_p) : 1;
  localparam int off_lp   = $clog2(word_width_p / 8);
  localparam logic [cnt_w_lp-1:0] max_out_lp = cnt_w_lp'(max_outstanding_p);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]               state_r;
  logic [paddr_width_p-1:0] base_r;
  logic [cnt_w_lp-1:0]      len_r;
  logic [sel_w_lp-1:0]      sel_r;
  logic [cnt_w_lp-1:0]      issued_r, completed_r;
  logic                     done_r, err_r, aborted_r;

  logic [cnt_w_lp-1:0] outstanding, issued_n, completed_n;
  logic in_xfer, cmd_v, cmd_fire, resp_acc, resp_bad, resp_ok, spm_w, bad_start;

  // Issue/accept decode; every output is gated so IDLE (and reset) drives zeros.
  always_comb begin
    outstanding = issued_r - completed_r;
    in_xfer     = (state_r == RUN) || (state_r == DRAIN);
    cmd_v       = (state_r == RUN) && (issued_r < len_r) && (outstanding < max_out_lp);
    cmd_fire    = cmd_v && bus.mem_cmd_yumi_i;
    resp_acc    = bus.mem_resp_v_i && in_xfer;
    resp_bad    = resp_acc && (outstanding == '0);
    resp_ok     = resp_acc && !resp_bad;
    spm_w       = resp_ok && (state_r == RUN);
    issued_n    = issued_r + cnt_w_lp'(cmd_fire);
    completed_n = completed_r + cnt_w_lp'(resp_ok);
    bad_start   = (int'(start_sel_i) >= num_spm_p) || (int'(start_len_i) > spm_els_p);

    bus.mem_cmd_v_o      = cmd_v;
    bus.mem_cmd_addr_o   = cmd_v ? base_r + (paddr_width_p'(issued_r) << off_lp) : '0;
    bus.mem_resp_ready_o = in_xfer;
    bus.spm_w_v_o        = spm_w;
    bus.spm_sel_o        = spm_w ? sel_r : '0;
    bus.spm_addr_o       = spm_w ? completed_r[idx_w_lp-1:0] : '0;
    bus.spm_data_o       = spm_w ? bus.mem_resp_data_i : '0;

    busy_o    = in_xfer;
    done_o    = done_r;
    err_o     = err_r;
    aborted_o = aborted_r;
  end

  // Transfer state, counters and sticky status.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r     <= IDLE;
      base_r      <= '0;
      len_r       <= '0;
      sel_r       <= '0;
      issued_r    <= '0;
      completed_r <= '0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      aborted_r   <= 1'b0;
    end else begin
      issued_r    <= issued_n;
      completed_r <= completed_n;
      if (resp_bad) err_r <= 1'b1;
      case (state_r)
        IDLE, DONE: begin
          if (start_v_i) begin
            // A rejected start runs as a zero-length transfer so that it reaches
            // DONE through RUN with the same timing as len=0, never issuing.
            base_r      <= start_addr_i;
            sel_r       <= start_sel_i;
            len_r       <= bad_start ? '0 : start_len_i;
            issued_r    <= '0;
            completed_r <= '0;
            done_r      <= 1'b0;
            err_r       <= bad_start;
            aborted_r   <= 1'b0;
            state_r     <= RUN;
          end else if ((state_r == DONE) && clear_i) begin
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            aborted_r <= 1'b0;
            state_r   <= IDLE;
          end
        end
        RUN: begin
          if (abort_i) begin
            // Judge emptiness on post-edge counts so a same-cycle issue or
            // response is neither stranded nor waited on.
            aborted_r <= 1'b1;
            if (issued_n == completed_n) begin
              state_r <= DONE;
              done_r  <= 1'b1;
            end else begin
              state_r <= DRAIN;
            end
          end else if (completed_r == len_r) begin
            state_r <= DONE;
            done_r  <= 1'b1;
          end
        end
        DRAIN: begin
          if (outstanding == '0) begin
            state_r <= DONE;
            done_r  <= 1'b1;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bp_sacc_dma_fill.sv
// Directed bench for bp_sacc_dma_fill with a latency-configurable memory model.
module tb_bp_sacc_dma_fill;
  localparam int BIG = 1000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_v = 1'b0;
  logic [39:0] start_addr = '0;
  logic [12:0] start_len = '0;
  logic [1:0]  start_sel = '0;
  logic        abort = 1'b0;
  logic        clear = 1'b0;
  logic        busy, done, err, aborted;

  always #5 clk = ~clk;

  bp_sacc_dma_fill_if #(.word_width_p(32), .paddr_width_p(40), .num_spm_p(3), .spm_els_p(4096)) bus ();

  bp_sacc_dma_fill #(
    .word_width_p(32), .paddr_width_p(40), .num_spm_p(3),
    .spm_els_p(4096), .max_outstanding_p(4)
  ) dut (
    .clk_i(clk), .reset_i(rst), .start_v_i(start_v), .start_addr_i(start_addr),
    .start_len_i(start_len), .start_sel_i(start_sel), .abort_i(abort), .clear_i(clear),
    .bus(bus), .busy_o(busy), .done_o(done), .err_o(err), .aborted_o(aborted)
  );

  int n_chk = 0;
  int n_bad = 0;

  // memory model controls and observation logs
  int cyc = 0;
  int lat = 2;
  int cmd_allow = BIG;
  int resp_allow = BIG;
  bit spurious = 1'b0;
  logic [39:0] cmd_q[$];
  int          due_q[$];
  logic [39:0] cmd_log[$];
  logic [31:0] wr_data[$];
  logic [11:0] wr_addr[$];
  logic [1:0]  wr_sel[$];
  int n_acc = 0;
  int n_cmdv = 0;

  always @(negedge clk) begin
    cyc++;
    bus.mem_cmd_yumi_i = bus.mem_cmd_v_o && (cmd_allow > 0);
    if (spurious) begin
      bus.mem_resp_v_i    = 1'b1;
      bus.mem_resp_data_i = 32'h5A5A_0000;
    end else if (cmd_q.size() > 0 && due_q[0] <= cyc && resp_allow > 0) begin
      bus.mem_resp_v_i    = 1'b1;
      bus.mem_resp_data_i = cmd_q[0][31:0] ^ 32'hDEAD_0000;
    end else begin
      bus.mem_resp_v_i    = 1'b0;
      bus.mem_resp_data_i = '0;
    end
    #1;
    if (bus.mem_cmd_v_o) n_cmdv++;
    if (bus.mem_cmd_v_o && bus.mem_cmd_yumi_i) begin
      cmd_log.push_back(bus.mem_cmd_addr_o);
      cmd_q.push_back(bus.mem_cmd_addr_o);
      due_q.push_back(cyc + lat);
      cmd_allow--;
    end
    if (bus.mem_resp_v_i && bus.mem_resp_ready_o) begin
      n_acc++;
      if (!spurious) begin
        void'(cmd_q.pop_front());
        void'(due_q.pop_front());
        resp_allow--;
      end
    end
    if (bus.spm_w_v_o) begin
      wr_data.push_back(bus.spm_data_o);
      wr_addr.push_back(bus.spm_addr_o);
      wr_sel.push_back(bus.spm_sel_o);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic clear_logs();
    cmd_log.delete(); wr_data.delete(); wr_addr.delete(); wr_sel.delete();
    n_acc = 0; n_cmdv = 0;
  endtask

  task automatic kick(input logic [39:0] a, input logic [12:0] l, input logic [1:0] s);
    start_addr = a; start_len = l; start_sel = s; start_v = 1'b1;
    tick();
    start_v = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (!done && k < budget) begin tick(); k++; end
    check(tag, done, 1);
  endtask

  task automatic do_clear();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  initial begin
    tick(2);
    check("rst_outs", {bus.mem_cmd_v_o, bus.mem_resp_ready_o, bus.spm_w_v_o, busy, done, err, aborted}, 0);
    check("rst_addr", bus.mem_cmd_addr_o, 0);
    rst = 1'b0;
    tick();

    // basic 8-word fill, zero-latency yumi, 2-cycle response
    clear_logs();
    kick(40'h30_0000, 8, 1);
    wait_done("t1_done", 100);
    check("t1_ncmd", cmd_log.size(), 8);
    check("t1_nwr", wr_addr.size(), 8);
    for (int i = 0; i < 8; i++) begin
      check("t1_cmd", (i < cmd_log.size()) ? cmd_log[i] : '1, 40'h30_0000 + 4 * i);
      check("t1_waddr", (i < wr_addr.size()) ? wr_addr[i] : '1, i);
      check("t1_wsel", (i < wr_sel.size()) ? wr_sel[i] : '1, 1);
      check("t1_wdata", (i < wr_data.size()) ? wr_data[i] : '1, (32'h30_0000 + 4 * i) ^ 32'hDEAD_0000);
    end
    check("t1_err", err, 0);
    check("t1_busy", busy, 0);
    do_clear();
    check("clr_flags", {busy, done, err, aborted}, 0);

    // outstanding limit with responses withheld
    clear_logs();
    resp_allow = 0;
    kick(40'h1000, 16, 0);
    tick(10);
    check("t2_stall", cmd_log.size(), 4);
    check("t2_noacc", n_acc, 0);
    resp_allow = 1;
    tick(6);
    check("t2_slot", cmd_log.size(), 5);
    check("t2_acc1", n_acc, 1);
    resp_allow = BIG;
    wait_done("t2_done", 200);
    check("t2_ncmd", cmd_log.size(), 16);
    check("t2_last", (wr_data.size() == 16) ? wr_data[15] : '1, 32'h103C ^ 32'hDEAD_0000);
    do_clear();

    // zero length and bad starts
    clear_logs();
    kick(40'h0, 0, 0);
    check("t3_run", {busy, done}, 2'b10);
    tick();
    check("t3_done", {busy, done, err}, 3'b010);
    check("t3_nocmd", n_cmdv, 0);
    kick(40'h0, 4, 3);
    wait_done("t3_sel_done", 20);
    check("t3_sel_err", err, 1);
    do_clear();
    kick(40'h0, 4097, 0);
    wait_done("t3_len_done", 20);
    check("t3_len_err", err, 1);
    check("t3_nocmd2", n_cmdv, 0);
    do_clear();

    // abort after 3 issued, 1 completed
    clear_logs();
    lat = 1; cmd_allow = 3; resp_allow = 1;
    kick(40'h2000, 8, 2);
    begin
      int k = 0;
      while (!(n_acc == 1 && cmd_log.size() == 3) && k < 50) begin tick(); k++; end
      check("t4_setup", (n_acc == 1 && cmd_log.size() == 3), 1);
    end
    abort = 1'b1; tick(); abort = 1'b0;
    check("t4_drain", {busy, aborted, done}, 3'b110);
    resp_allow = BIG;
    wait_done("t4_done", 50);
    check("t4_acc", n_acc, 3);
    check("t4_nwr", wr_data.size(), 1);
    check("t4_flags", {aborted, err}, 2'b10);
    check("t4_ncmd", cmd_log.size(), 3);
    cmd_allow = BIG; lat = 2;
    do_clear();

    // stray response is a protocol error; abort with nothing outstanding
    clear_logs();
    cmd_allow = 0;
    kick(40'h4000, 4, 0);
    tick(2);
    spurious = 1'b1; tick(); spurious = 1'b0; tick();
    check("t5_err", err, 1);
    check("t5_nwr", wr_data.size(), 0);
    abort = 1'b1; tick(); abort = 1'b0;
    check("t5_direct", {busy, done, aborted}, 3'b011);
    cmd_allow = BIG;
    do_clear();

    // start while busy is ignored; start beats clear in DONE
    clear_logs();
    kick(40'h5000, 4, 1);
    tick();
    kick(40'h9000, 8, 0);
    wait_done("t6_done", 100);
    check("t6_ncmd", cmd_log.size(), 4);
    check("t6_first", (cmd_log.size() > 0) ? cmd_log[0] : '1, 40'h5000);
    check("t6_sel", (wr_sel.size() == 4) ? wr_sel[3] : '1, 1);
    do_clear();
    check("t6_idle", {busy, done, err, aborted}, 0);
    kick(40'h6000, 2, 2);
    wait_done("t6_done2", 50);
    clear_logs();
    clear = 1'b1;
    kick(40'h7000, 2, 0);
    clear = 1'b0;
    check("t6_prio", {busy, done}, 2'b10);
    wait_done("t6_done3", 50);
    check("t6_last", (cmd_log.size() == 2) ? cmd_log[1] : '1, 40'h7004);
    do_clear();

    // asynchronous reset mid-transfer
    clear_logs();
    resp_allow = 0;
    kick(40'h8000, 8, 1);
    tick(3);
    check("t7_busy", busy, 1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("t7_outs", {bus.mem_cmd_v_o, bus.mem_resp_ready_o, bus.spm_w_v_o, busy, done, err, aborted}, 0);
    check("t7_addr", bus.mem_cmd_addr_o, 0);
    resp_allow = BIG;
    tick(2);
    rst = 1'b0;
    tick(3);
    check("t7_late", n_acc, 0);
    check("t7_nwr", wr_data.size(), 0);
    cmd_q.delete(); due_q.delete();
    tick();
    clear_logs();
    kick(40'h100, 4, 2);
    wait_done("t7_done", 100);
    check("t7_wr", wr_data.size(), 4);
    check("t7_data", (wr_data.size() == 4) ? wr_data[3] : '1, 32'h10C ^ 32'hDEAD_0000);
    check("t7_err", err, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
